// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port memory between the fetch and MEM stages, with data-side priority.
// Optional per-requester wait-cycle counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       if_wait_cnt_o,
    output logic [31:0]       dm_wait_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SERVE_IF = 2'd1;
    localparam logic [1:0] ST_SERVE_DM = 2'd2;

    logic [1:0]        r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_if_ack;
    logic              w_dm_ack;

    // Request attributes are captured at the grant edge so the memory sees a stable access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dm_req_i) begin
                        r_state     <= ST_SERVE_DM;
                        r_mem_we    <= dm_we_i;
                        r_mem_addr  <= dm_addr_i;
                        r_mem_wdata <= dm_wdata_i;
                    end else if (if_req_i) begin
                        r_state     <= ST_SERVE_IF;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr_i;
                        r_mem_wdata <= '0;
                    end
                end
                ST_SERVE_IF, ST_SERVE_DM: begin
                    if (mem_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A requester that has already dropped its request completes silently.
    assign w_if_ack = ~rst_i & (r_state == ST_SERVE_IF) & mem_ready_i & if_req_i;
    assign w_dm_ack = ~rst_i & (r_state == ST_SERVE_DM) & mem_ready_i & dm_req_i;

    assign if_ack_o    = w_if_ack;
    assign dm_ack_o    = w_dm_ack;
    assign if_rdata_o  = w_if_ack ? mem_rdata_i : '0;
    assign dm_rdata_o  = w_dm_ack ? mem_rdata_i : '0;
    assign mem_req_o   = (r_state == ST_SERVE_IF) | (r_state == ST_SERVE_DM);
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign stall_o     = (if_req_i & ~w_if_ack) | (dm_req_i & ~w_dm_ack);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_if_wait_cnt;
    logic [31:0] r_dm_wait_cnt;

    // Saturating counts of cycles each requester spends stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_if_wait_cnt <= '0;
            r_dm_wait_cnt <= '0;
        end else begin
            if (if_req_i && !w_if_ack && (r_if_wait_cnt != 32'hFFFF_FFFF)) begin
                r_if_wait_cnt <= r_if_wait_cnt + 32'd1;
            end
            if (dm_req_i && !w_dm_ack && (r_dm_wait_cnt != 32'hFFFF_FFFF)) begin
                r_dm_wait_cnt <= r_dm_wait_cnt + 32'd1;
            end
        end
    end

    assign if_wait_cnt_o = r_if_wait_cnt;
    assign dm_wait_cnt_o = r_dm_wait_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
// Counter checks are included when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_wait_cnt;
    logic [31:0] dm_wait_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_ack_o    (if_ack),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_ack_o    (dm_ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .stall_o     (stall)
`ifdef MEM_ARB_PERF_EN
        ,
        .if_wait_cnt_o (if_wait_cnt),
        .dm_wait_cnt_o (dm_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory idle: no request out, no acks, zero read data, stall as given.
    task automatic chk_idle(input string tag, input bit exp_stall);
        chk({tag, "_mreq"},   64'(mem_req),  64'd0);
        chk({tag, "_ifack"},  64'(if_ack),   64'd0);
        chk({tag, "_dmack"},  64'(dm_ack),   64'd0);
        chk({tag, "_ifrd"},   64'(if_rdata), 64'd0);
        chk({tag, "_dmrd"},   64'(dm_rdata), 64'd0);
        chk({tag, "_stall"},  64'(stall),    64'(exp_stall));
    endtask

    // Called one step after the grant edge. The memory answers after d wait cycles;
    // the served requester optionally drops its request right after the grant.
    task automatic serve(input bit is_dm, input int d, input bit drop,
                         input logic [31:0] rd, input bit other_pending);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ew;
        bit          live;
        bit          last;
        ea   = is_dm ? dm_addr : if_addr;
        ew   = is_dm ? dm_we : 1'b0;
        ewd  = dm_wdata;
        live = 1'b1;
        for (int k = 0; k <= d; k++) begin
            last = (k == d);
            if (drop && k == 0) begin
                live = 1'b0;
                if (is_dm) dm_req = 1'b0;
                else       if_req = 1'b0;
            end
            mem_ready = last;
            mem_rdata = last ? rd : $urandom;
            #1;
            chk("srv_mreq", 64'(mem_req), 64'd1);
            chk("srv_addr", 64'(mem_addr), 64'(ea));
            chk("srv_we",   64'(mem_we), 64'(ew));
            if (is_dm) chk("srv_wdata", 64'(mem_wdata), 64'(ewd));
            chk("srv_ifack", 64'(if_ack), 64'(!is_dm && live && last));
            chk("srv_dmack", 64'(dm_ack), 64'(is_dm && live && last));
            chk("srv_ifrd",  64'(if_rdata), (!is_dm && live && last) ? 64'(rd) : 64'd0);
            chk("srv_dmrd",  64'(dm_rdata), (is_dm && live && last) ? 64'(rd) : 64'd0);
            chk("srv_stall", 64'(stall), 64'((live && !last) || other_pending));
            tick;
        end
        if (is_dm) dm_req = 1'b0;
        else       if_req = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk_idle("gap", other_pending);
    endtask

    initial begin
        logic [31:0] rd;
        int          kind;
        int          d1;
        int          d2;
        bit          drop1;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        tick; tick;
        #1;
        chk_idle("rst", 1'b0);
        chk("rst_we",    64'(mem_we),    64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        if_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        chk("rst_stall_req", 64'(stall),  64'd1);
        chk("rst_ifack",     64'(if_ack), 64'd0);
        tick;
        rst = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
        tick;

        // Single fetch at 0x10, ready one cycle after mem_req
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk_idle("f_req", 1'b1);
        tick;
        serve(1'b0, 1, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Simultaneous request: data side first, then fetch
        tick;
        if_req = 1'b1; if_addr = 32'h104; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        #1;
        chk_idle("both_req", 1'b1);
        tick;
        serve(1'b1, 0, 1'b0, 32'hA5A5_0001, 1'b1);
        tick;
        serve(1'b0, 2, 1'b0, 32'h5A5A_0002, 1'b0);

        // Store held stable over a 5-cycle ready delay
        tick;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        #1;
        chk_idle("st_req", 1'b1);
        tick;
        serve(1'b1, 5, 1'b0, 32'h0BAD_0BAD, 1'b0);

        // Dropped data request
        tick;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        #1;
        tick;
        serve(1'b1, 3, 1'b1, 32'h7777_7777, 1'b0);

        // Reset in the middle of a fetch
        tick;
        if_req = 1'b1; if_addr = 32'h30;
        tick;
        chk("ra_mreq", 64'(mem_req), 64'd1);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
        #1;
        chk("ra_ifack", 64'(if_ack),   64'd0);
        chk("ra_ifrd",  64'(if_rdata), 64'd0);
        tick;
        rst = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("ra_mreq_off", 64'(mem_req),  64'd0);
        chk("ra_addr",     64'(mem_addr), 64'd0);
        tick;
        mem_ready = 1'b1;
        #1;
        chk("ra_late_ack",  64'(if_ack),  64'd0);
        chk("ra_late_mreq", 64'(mem_req), 64'd0);
        tick;
        mem_ready = 1'b0;

        // Randomized transactions; model: data side wins whenever both are pending
        for (int it = 0; it < 40; it++) begin
            tick;
            kind  = int'($urandom_range(0, 2));
            d1    = int'($urandom_range(0, 4));
            d2    = int'($urandom_range(0, 4));
            drop1 = ($urandom_range(0, 4) == 0);
            if_addr  = $urandom;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            dm_we    = 1'($urandom_range(0, 1));
            if_req   = (kind != 1);
            dm_req   = (kind != 0);
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk_idle("rnd_req", 1'b1);
            tick;
            rd = $urandom;
            serve(kind != 0, d1, drop1, rd, kind == 2);
            if (kind == 2) begin
                tick;
                rd = $urandom;
                serve(1'b0, d2, 1'b0, rd, 1'b0);
            end
        end
        tick;
        mem_ready = 1'b0;

`ifdef MEM_ARB_PERF_EN
        // Fetch that waits 3 cycles before its ack
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("cnt_rst_if", 64'(if_wait_cnt), 64'd0);
        chk("cnt_rst_dm", 64'(dm_wait_cnt), 64'd0);
        tick;
        if_req = 1'b1; if_addr = 32'h50;
        #1;
        tick;
        serve(1'b0, 2, 1'b0, 32'h5555_AAAA, 1'b0);
        chk("cnt_if", 64'(if_wait_cnt), 64'd3);
        chk("cnt_dm", 64'(dm_wait_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
